// File: rtl/s_sel_pkg.sv
// Shared definitions for the S-operand select/arbiter block.
package s_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Width of a source-index field for n sources (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/s_sel_arb_if.sv
// Source/sink handshake bundle of the S-operand select stage.
interface s_sel_arb_if
    import s_sel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) ();
    localparam int SELW = idx_w(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH-1:0]         in_valid;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_src;
    logic                   out_ready;

    // Environment side: sources plus downstream consumer.
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    // Select stage side.
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches requests from ptr upward with wrap,
// ptr moves past the winner when the caller strobes advance.
module rr_arbiter
    import s_sel_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = idx_w(NCH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);
    logic [SELW-1:0] ptr;

    // First requester at or after ptr, wrapping at NCH (not 2**SELW).
    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(j);
                gnt[j]  = 1'b1;
            end
        end
    end

    // Pointer moves one past the granted source on each accepted transfer.
    always_ff @(posedge clk) begin
        if (!reset_n)
            ptr <= '0;
        else if (advance && gnt_vld)
            ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/s_sel_arb.sv
// S-operand select: direct mux or round-robin pick among NCH sources,
// registered into a single-entry valid/ready output stage.
module s_sel_arb
    import s_sel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    localparam int SELW = idx_w(NCH)
) (
    input  logic         clk,
    input  logic         reset_n,
    s_sel_arb_if.slave   bus
);
    logic [NCH-1:0]  rr_gnt, dir_gnt, gnt;
    logic [SELW-1:0] rr_idx, dir_idx, g_idx;
    logic            rr_vld, dir_vld, g_vld;
    logic            can_load, xfer;
    logic [WIDTH-1:0] g_data;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_src_q;

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.in_valid),
        .advance (xfer && (bus.mode == MODE_RR)),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Direct decode; a sel value of NCH or above simply matches nothing.
    always_comb begin
        dir_gnt = '0;
        dir_vld = 1'b0;
        dir_idx = bus.sel;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == bus.sel && bus.in_valid[i]) begin
                dir_gnt[i] = 1'b1;
                dir_vld    = 1'b1;
            end
        end
    end

    // Mode picks the grant source every cycle; one-hot grant drives the data mux.
    always_comb begin
        gnt    = (bus.mode == MODE_RR) ? rr_gnt : dir_gnt;
        g_idx  = (bus.mode == MODE_RR) ? rr_idx : dir_idx;
        g_vld  = (bus.mode == MODE_RR) ? rr_vld : dir_vld;
        g_data = '0;
        for (int i = 0; i < NCH; i++)
            if (gnt[i]) g_data = bus.in_data[i*WIDTH +: WIDTH];
    end

    assign can_load     = !out_valid_q || bus.out_ready;
    assign xfer         = g_vld && can_load && reset_n;
    assign bus.in_ready = gnt & {NCH{can_load && reset_n}};

    // Output stage: load on transfer, otherwise drain when consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= g_data;
            out_src_q   <= g_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_s_sel_arb.sv
// Directed bench for s_sel_arb: NCH=4 table plus NCH=3 wrap/range checks.
module tb_s_sel_arb;
    import s_sel_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    s_sel_arb_if #(.WIDTH(16), .NCH(4)) bus4 ();
    s_sel_arb_if #(.WIDTH(16), .NCH(3)) bus3 ();

    s_sel_arb #(.WIDTH(16), .NCH(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
    s_sel_arb #(.WIDTH(16), .NCH(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        localparam logic RR = MODE_RR;
        localparam logic DR = MODE_DIRECT;
        // Sources 0..3 carry 1111, 2222, 3333, 4444.
        tbl[0]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[1]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[2]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333};
        tbl[3]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[4]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[5]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[6]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333};
        tbl[7]  = '{RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[8]  = '{RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[9]  = '{RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[10] = '{RR, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[11] = '{RR, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[12] = '{DR, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333};
        tbl[13] = '{DR, 2'd1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3333};
        tbl[14] = '{RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3333};
        tbl[15] = '{RR, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[16] = '{RR, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h1111};
        tbl[17] = '{RR, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h1111};
        tbl[18] = '{RR, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h1111};
        tbl[19] = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
        tbl[20] = '{DR, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111};
        tbl[21] = '{RR, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3333};
        tbl[22] = '{DR, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[23] = '{RR, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
        tbl[24] = '{RR, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h4444};

        bus4.mode = MODE_RR; bus4.sel = '0; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
        bus4.in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus3.mode = MODE_RR; bus3.sel = '0; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
        bus3.in_data = {16'h3332, 16'h3331, 16'h3330};

        // Reset held two cycles with all sources valid.
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(bus4.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("reset out_valid", 32'(bus4.out_valid), 32'h0);
        chk("reset out_data",  32'(bus4.out_data),  32'h0);
        chk("reset out_src",   32'(bus4.out_src),   32'h0);
        chk("reset3 out_valid", 32'(bus3.out_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: one vector per cycle, ready checked before the edge, outputs after.
        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk);
            bus4.mode = tbl[i].mode;
            bus4.sel = tbl[i].sel;
            bus4.in_valid = tbl[i].vld;
            bus4.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(bus4.in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus4.out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("v%0d out_src", i),   32'(bus4.out_src),   32'(tbl[i].exp_src));
            chk($sformatf("v%0d out_data", i),  32'(bus4.out_data),  32'(tbl[i].exp_data));
        end

        // Direct load of BEEF, then 3 cycles of back-pressure with a new word waiting.
        @(negedge clk);
        bus4.in_data[47:32] = 16'hBEEF;
        bus4.in_data[31:16] = 16'hCAFE;
        bus4.mode = MODE_DIRECT; bus4.sel = 2'd2; bus4.in_valid = 4'b0100; bus4.out_ready = 1'b1;
        #1 chk("beef in_ready", 32'(bus4.in_ready), 32'b0100);
        @(posedge clk); #1;
        chk("beef out_valid", 32'(bus4.out_valid), 32'h1);
        chk("beef out_data",  32'(bus4.out_data),  32'hBEEF);
        chk("beef out_src",   32'(bus4.out_src),   32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus4.sel = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b0;
            #1 chk($sformatf("bp%0d in_ready", c), 32'(bus4.in_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", c), 32'(bus4.out_valid), 32'h1);
            chk($sformatf("bp%0d out_data", c),  32'(bus4.out_data),  32'hBEEF);
            chk($sformatf("bp%0d out_src", c),   32'(bus4.out_src),   32'h2);
        end
        @(negedge clk);
        bus4.out_ready = 1'b1;
        #1 chk("drain+load in_ready", 32'(bus4.in_ready), 32'b0010);
        @(posedge clk); #1;
        chk("drain+load out_valid", 32'(bus4.out_valid), 32'h1);
        chk("drain+load out_data",  32'(bus4.out_data),  32'hCAFE);
        chk("drain+load out_src",   32'(bus4.out_src),   32'h1);

        // Reset while a transfer is being offered: the word is discarded.
        @(negedge clk);
        bus4.sel = 2'd0; bus4.in_valid = 4'b0001;
        reset_n = 1'b0;
        #1 chk("midrst in_ready", 32'(bus4.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("midrst out_valid", 32'(bus4.out_valid), 32'h0);
        chk("midrst out_data",  32'(bus4.out_data),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus4.in_valid = 4'b0000;

        // NCH=3: round-robin wraps 2 -> 0.
        bus3.mode = MODE_RR; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            @(posedge clk); #1;
            chk($sformatf("n3 rr%0d out_src", i),  32'(bus3.out_src),  32'(i % 3));
            chk($sformatf("n3 rr%0d out_data", i), 32'(bus3.out_data), 32'(16'h3330 + (i % 3)));
        end
        @(negedge clk);
        bus3.in_valid = 3'b000;
        @(posedge clk); #1;
        chk("n3 drain out_valid", 32'(bus3.out_valid), 32'h0);

        // NCH=3: sel=3 is out of range, sel=2 is the top legal source.
        @(negedge clk);
        bus3.mode = MODE_DIRECT; bus3.sel = 2'd3; bus3.in_valid = 3'b111;
        #1 chk("n3 sel3 in_ready", 32'(bus3.in_ready), 32'h0);
        @(posedge clk); #1;
        chk("n3 sel3 out_valid", 32'(bus3.out_valid), 32'h0);
        @(negedge clk);
        bus3.sel = 2'd2;
        #1 chk("n3 sel2 in_ready", 32'(bus3.in_ready), 32'b100);
        @(posedge clk); #1;
        chk("n3 sel2 out_valid", 32'(bus3.out_valid), 32'h1);
        chk("n3 sel2 out_data",  32'(bus3.out_data),  32'h3332);
        chk("n3 sel2 out_src",   32'(bus3.out_src),   32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s_sel_arb.md
# s_sel_arb

Parametrised successor to the datapath S-operand select: chooses one of NCH WIDTH-bit sources per cycle and registers it into a single-entry output stage with valid/ready handshakes on both sides. Sources are selected either directly by a select field (classic mux mode) or by round-robin arbitration among valid requesters. It sits between the register-file/data-memory sources and the ALU S-operand input, and absorbs back-pressure that the plain combinational mux cannot.

## Interface
- Reset is synchronous and active-low; one clock.
- WIDTH, 16, data width of each source and of the output
- NCH, 4, number of sources; legal range 2..16, need not be a power of two
- SELW, derived = clog2(NCH), width of select/source-index fields
- clk  input  1  sole clock, rising edge
- reset_n  input  1  synchronous active-low reset
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SELW  source index used in direct mode
- in_valid  input  NCH  per-source data valid
- in_data  input  NCH*WIDTH  flattened sources, source i at bits [i*WIDTH +: WIDTH]
- in_ready  output  NCH  per-source accept, combinational; at most one bit high
- out_valid  output  1  output register holds data
- out_data  output  WIDTH  registered selected data
- out_src  output  SELW  index of source that produced out_data
- out_ready  input  1  downstream accepts out_data

## Operation
- can_load = !out_valid | out_ready.
- Direct mode: grant = sel when sel < NCH and in_valid[sel]; else no grant. sel >= NCH: no grant, all in_ready 0.
- Round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, ..., wrapping NCH-1 -> 0.
- in_ready[grant] = can_load; all other in_ready bits 0. in_ready never depends on in_valid of non-granted sources.
- Transfer on source g: in_valid[g] & in_ready[g]. On transfer: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- No transfer while out_valid & out_ready: out_valid <= 0; out_data/out_src hold.
- ptr (SELW bits) updates only on a round-robin-mode transfer: ptr <= (g == NCH-1) ? 0 : g+1. Direct-mode transfers leave ptr unchanged.
- mode and sel are sampled combinationally every cycle; a change takes effect in the same cycle, no flush.
- out_data and out_src hold stable while out_valid & !out_ready.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 transfer/cycle when out_ready is held high (simultaneous drain and load).
- Reset (reset_n low at rising edge): out_valid = 0, out_data = 0, out_src = 0, ptr = 0; in_ready = 0 during the reset cycle. Reset mid-transfer discards the held word; the source is not considered accepted.
- Full (out_valid & !out_ready): all in_ready 0; state holds.
- Empty with no grant: out_valid stays 0; ptr holds.
- Simultaneous valid on all sources in round-robin mode: grants rotate 0,1,...,NCH-1,0 on consecutive transfers.

## Structure
- Shared package s_sel_pkg: MODE_DIRECT = 1'b0, MODE_RR = 1'b1, and a clog2-based index-width function used for SELW.
- One sub-module: rr_arbiter (NCH requests in, ptr register, one-hot grant plus encoded index out, advance strobe). The direct path and the output register stay in s_sel_arb.

## Test plan
- Reset: reset_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0; first RR grant after release is source 0.
- Direct mode, WIDTH=16, NCH=4: sel=2, in_data[2]=16'hBEEF, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_src=2.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with new valid inputs -> in_ready=0, out_data unchanged; out_ready=1 -> drain and load in the same cycle, out_valid remains 1 with the new word.
- Round-robin fairness: in_valid=4'b1111, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; with in_valid=4'b1010 -> 1,3,1,3.
- Non-power-of-two wrap, NCH=3: RR with all valid -> out_src 0,1,2,0; direct sel=3 -> in_ready=0, out_valid stays 0.
- Mode switch: RR grants source 1 (ptr=2), switch to direct sel=0 for one transfer, switch back -> next RR grant is source 2 (ptr was not moved by the direct transfer).
